// File: rtl/vdp_pkg.sv
// Shared types and default glyph/framebuffer geometry for the video display processor blocks.
package vdp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAW,
        ST_DONE
    } blit_state_t;

    localparam int DEF_GLYPH_W = 8;
    localparam int DEF_GLYPH_H = 8;
    localparam int DEF_FB_W    = 320;

endpackage

// File: rtl/glyph_blit.sv
// Character blitter: reads one glyph row per pass from an external character ROM and
// writes it pixel by pixel into an external framebuffer, optionally skipping background pixels.
module glyph_blit
    import vdp_pkg::*;
#(
    parameter int PIXW    = 24,
    parameter int VADR    = 16,
    parameter int CADR    = 11,
    parameter int FB_W    = DEF_FB_W,
    parameter int GLYPH_W = DEF_GLYPH_W,
    parameter int GLYPH_H = DEF_GLYPH_H
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_char,
    input  logic [VADR-1:0]    req_x,
    input  logic [VADR-1:0]    req_y,
    input  logic [PIXW-1:0]    req_fg,
    input  logic [PIXW-1:0]    req_bg,
    input  logic               req_transp,
    output logic [CADR-1:0]    crom_adr,
    input  logic [GLYPH_W-1:0] crom_q,
    output logic [VADR-1:0]    vram_wadr,
    output logic [PIXW-1:0]    vram_d,
    output logic               vram_we,
    output logic               busy,
    output logic               done
);

    localparam int CW  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int RW  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    // Products are formed at full width and only truncated at the port.
    localparam int CAW = 8 + RW + 2;
    localparam int PW  = VADR + $clog2(FB_W + 1) + 3;

    blit_state_t        r_state;
    blit_state_t        w_next_state;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      r_col;
    logic [7:0]         r_char;
    logic [VADR-1:0]    r_x;
    logic [VADR-1:0]    r_y;
    logic [PIXW-1:0]    r_fg;
    logic [PIXW-1:0]    r_bg;
    logic               r_transp;
    logic [GLYPH_W-1:0] r_bits;

    logic               w_last_col;
    logic               w_last_row;
    logic               w_pix;
    logic [CADR-1:0]    w_crom_adr;
    logic [VADR-1:0]    w_pix_adr;

    assign w_last_col = (r_col == CW'(GLYPH_W - 1));
    assign w_last_row = (r_row == RW'(GLYPH_H - 1));
    assign w_pix      = r_bits[GLYPH_W-1];
    assign w_crom_adr = CADR'(CAW'(r_char) * CAW'(GLYPH_H) + CAW'(r_row));
    assign w_pix_adr  = VADR'((PW'(r_y) + PW'(r_row)) * PW'(FB_W) + PW'(r_x) + PW'(r_col));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = ST_DRAW;
            ST_DRAW:  if (w_last_col) w_next_state = w_last_row ? ST_DONE : ST_FETCH;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        crom_adr  = '0;
        vram_wadr = '0;
        vram_d    = '0;
        vram_we   = 1'b0;
        case (r_state)
            ST_FETCH, ST_WAIT: crom_adr = w_crom_adr;
            ST_DRAW: begin
                vram_wadr = w_pix_adr;
                vram_d    = w_pix ? r_fg : r_bg;
                vram_we   = w_pix | ~r_transp;
            end
            default: ;
        endcase
    end

    // Row/column counters advance with the FSM; the row wraps harmlessly after the last pass.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_row <= '0;
                ST_WAIT: r_col <= '0;
                ST_DRAW: begin
                    r_col <= r_col + CW'(1);
                    if (w_last_col) r_row <= r_row + RW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (r_state == ST_IDLE && req_valid) begin
            r_char   <= req_char;
            r_x      <= req_x;
            r_y      <= req_y;
            r_fg     <= req_fg;
            r_bg     <= req_bg;
            r_transp <= req_transp;
        end
        if (r_state == ST_WAIT) begin
            r_bits <= crom_q;
        end else if (r_state == ST_DRAW) begin
            r_bits <= r_bits << 1;
        end
    end

endmodule

// File: tb/tb_glyph_blit.sv
// Scoreboard bench for glyph_blit: default 8x8 geometry plus a 16x16 / 640-pitch instance.
`timescale 1ns/1ps
module tb_glyph_blit;

    typedef struct packed {
        logic [15:0] a;
        logic [23:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic        a_valid, a_ready, a_transp, a_we, a_busy, a_done;
    logic [7:0]  a_char;
    logic [15:0] a_x, a_y, a_wadr;
    logic [23:0] a_fg, a_bg, a_d;
    logic [10:0] a_crom_adr;
    logic [7:0]  a_crom_q;

    logic        b_valid, b_ready, b_transp, b_we, b_busy, b_done;
    logic [7:0]  b_char;
    logic [15:0] b_x, b_y, b_wadr;
    logic [23:0] b_fg, b_bg, b_d;
    logic [11:0] b_crom_adr;
    logic [15:0] b_crom_q;

    wr_t         q_a[$];
    wr_t         q_b[$];
    logic [15:0] log_a[$];
    logic [15:0] log_b[$];
    int          n_chk = 0;
    int          n_fail = 0;

    glyph_blit #(.PIXW(24), .VADR(16), .CADR(11), .FB_W(320), .GLYPH_W(8), .GLYPH_H(8)) u_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_char(a_char), .req_x(a_x), .req_y(a_y), .req_fg(a_fg), .req_bg(a_bg),
        .req_transp(a_transp), .crom_adr(a_crom_adr), .crom_q(a_crom_q),
        .vram_wadr(a_wadr), .vram_d(a_d), .vram_we(a_we), .busy(a_busy), .done(a_done)
    );

    glyph_blit #(.PIXW(24), .VADR(16), .CADR(12), .FB_W(640), .GLYPH_W(16), .GLYPH_H(16)) u_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_char(b_char), .req_x(b_x), .req_y(b_y), .req_fg(b_fg), .req_bg(b_bg),
        .req_transp(b_transp), .crom_adr(b_crom_adr), .crom_q(b_crom_q),
        .vram_wadr(b_wadr), .vram_d(b_d), .vram_we(b_we), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Character ROM contents: 'T', a diamond at code 1, and a hash elsewhere.
    function automatic logic [7:0] rom_a(input logic [10:0] ad);
        logic [7:0] v;
        if (ad[10:3] == 8'h54) begin
            v = (ad[2:0] == 3'd0) ? 8'hFF : (ad[2:0] == 3'd7) ? 8'h00 : 8'h18;
        end else if (ad[10:3] == 8'h01) begin
            case (ad[2:0])
                3'd0, 3'd7: v = 8'h81;
                3'd1, 3'd6: v = 8'h42;
                3'd2, 3'd5: v = 8'h24;
                default:    v = 8'h18;
            endcase
        end else begin
            v = ad[7:0] ^ {ad[10:8], 5'h0B};
        end
        return v;
    endfunction

    function automatic logic [15:0] rom_b(input logic [11:0] ad);
        return {ad[7:0] ^ 8'hA5, ad[11:4]};
    endfunction

    always @(posedge clk) a_crom_q <= rom_a(a_crom_adr);
    always @(posedge clk) b_crom_q <= rom_b(b_crom_adr);

    task automatic push_a(input logic [7:0] ch, input logic [15:0] x, input logic [15:0] y,
                          input logic [23:0] fg, input logic [23:0] bg, input logic tr);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] row;
            longint     full;
            wr_t        w;
            row = rom_a(11'(int'(ch) * 8 + r));
            for (int c = 0; c < 8; c++) begin
                if (row[7-c] || !tr) begin
                    full = (longint'(y) + r) * 320 + longint'(x) + c;
                    w.a = full[15:0];
                    w.d = row[7-c] ? fg : bg;
                    q_a.push_back(w);
                end
            end
        end
    endtask

    task automatic push_b(input logic [7:0] ch, input logic [15:0] x, input logic [15:0] y,
                          input logic [23:0] fg, input logic [23:0] bg, input logic tr);
        for (int r = 0; r < 16; r++) begin
            logic [15:0] row;
            longint      full;
            wr_t         w;
            row = rom_b(12'(int'(ch) * 16 + r));
            for (int c = 0; c < 16; c++) begin
                if (row[15-c] || !tr) begin
                    full = (longint'(y) + r) * 640 + longint'(x) + c;
                    w.a = full[15:0];
                    w.d = row[15-c] ? fg : bg;
                    q_b.push_back(w);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (a_we) begin
            log_a.push_back(a_wadr);
            if (q_a.size() == 0) begin
                chk("a_unexpected_we", a_we, 0);
            end else begin
                w = q_a.pop_front();
                chk("a_wadr", a_wadr, w.a);
                chk("a_wdata", a_d, w.d);
            end
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (b_we) begin
            log_b.push_back(b_wadr);
            if (q_b.size() == 0) begin
                chk("b_unexpected_we", b_we, 0);
            end else begin
                w = q_b.pop_front();
                chk("b_wadr", b_wadr, w.a);
                chk("b_wdata", b_d, w.d);
            end
        end
    end

    // Presents a request on a falling edge; returns 1 time unit after the accepting edge.
    task automatic issue(input bit sel, input logic [7:0] ch, input logic [15:0] x, input logic [15:0] y,
                         input logic [23:0] fg, input logic [23:0] bg, input logic tr, input bit keep);
        @(negedge clk);
        chk(sel ? "b_ready_pre" : "a_ready_pre", sel ? b_ready : a_ready, 1);
        if (!sel) begin
            a_char = ch; a_x = x; a_y = y; a_fg = fg; a_bg = bg; a_transp = tr; a_valid = 1'b1;
            push_a(ch, x, y, fg, bg, tr);
        end else begin
            b_char = ch; b_x = x; b_y = y; b_fg = fg; b_bg = bg; b_transp = tr; b_valid = 1'b1;
            push_b(ch, x, y, fg, bg, tr);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    // Counts falling edges until done; cycle 1 is the one right after the accepting edge.
    task automatic wait_done(input bit sel, output int cyc, output int rdy_hi, output int busy_lo);
        bit seen;
        seen = 0; cyc = 0; rdy_hi = 0; busy_lo = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sel ? b_done : a_done) begin
                seen = 1;
            end else begin
                if (sel ? b_ready : a_ready) rdy_hi++;
                if (!(sel ? b_busy : a_busy)) busy_lo++;
            end
        end
        if (!seen) cyc = -1;
    endtask

    initial begin
        int c, rh, bl, n, n_done;
        a_valid = 0; a_char = 0; a_x = 0; a_y = 0; a_fg = 0; a_bg = 0; a_transp = 0;
        b_valid = 0; b_char = 0; b_x = 0; b_y = 0; b_fg = 0; b_bg = 0; b_transp = 0;

        #25;
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_we", a_we, 0);
        chk("rst_crom", a_crom_adr, 0);
        chk("rst_wadr", a_wadr, 0);
        chk("rst_vd", a_d, 0);
        chk("rst_b_ready", b_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        log_a.delete();
        issue(0, 8'h54, 16'd100, 16'd0, 24'hFFFFFF, 24'h000000, 1'b0, 0);
        chk("T_first_crom", a_crom_adr, 11'h2A0);
        wait_done(0, c, rh, bl);
        chk("T_done_cycle", c, 81);
        chk("T_ready_low", rh, 0);
        chk("T_busy_gap", bl, 0);
        chk("T_writes", log_a.size(), 64);
        chk("T_first_adr", log_a[0], 100);
        chk("T_last_adr", log_a[$], 2347);
        @(negedge clk);
        chk("T_idle_ready", a_ready, 1);
        chk("T_sb_empty", q_a.size(), 0);

        log_a.delete();
        issue(0, 8'h01, 16'd10, 16'd5, 24'h00FF00, 24'h0000FF, 1'b1, 0);
        wait_done(0, c, rh, bl);
        chk("TR_done_cycle", c, 81);
        chk("TR_writes", log_a.size(), 16);
        chk("TR_r0_col0", log_a[0], 1610);
        chk("TR_r0_col7", log_a[1], 1617);
        chk("TR_r1_col1", log_a[2], 1931);
        @(negedge clk);
        chk("TR_sb_empty", q_a.size(), 0);

        log_a.delete();
        issue(0, 8'h54, 16'hFFFF, 16'd0, 24'h123456, 24'h654321, 1'b0, 0);
        wait_done(0, c, rh, bl);
        chk("WR_col0_adr", log_a[0], 16'hFFFF);
        chk("WR_col1_adr", log_a[1], 0);
        chk("WR_writes", log_a.size(), 64);
        @(negedge clk);
        chk("WR_sb_empty", q_a.size(), 0);

        log_a.delete();
        issue(0, 8'h41, 16'd20, 16'd30, 24'hAAAAAA, 24'h555555, 1'b0, 1);
        a_char = 8'h42; a_x = 16'd40; a_y = 16'd60; a_fg = 24'h0A0B0C; a_bg = 24'hC0B0A0; a_transp = 1'b0;
        push_a(8'h42, 16'd40, 16'd60, 24'h0A0B0C, 24'hC0B0A0, 1'b0);
        wait_done(0, c, rh, bl);
        chk("B2B_done1_cycle", c, 81);
        chk("B2B_ready_low", rh, 0);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (a_ready) break;
        end
        chk("B2B_idle_gap", n, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        wait_done(0, c, rh, bl);
        chk("B2B_done2_cycle", c, 81);
        chk("B2B_writes", log_a.size(), 128);
        @(negedge clk);
        chk("B2B_sb_empty", q_a.size(), 0);

        issue(0, 8'h54, 16'd0, 16'd50, 24'h111111, 24'h222222, 1'b0, 0);
        repeat (30) @(negedge clk);
        chk("RST_we_before", a_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("RST_we_async", a_we, 0);
        chk("RST_ready", a_ready, 1);
        chk("RST_busy", a_busy, 0);
        chk("RST_done", a_done, 0);
        chk("RST_crom", a_crom_adr, 0);
        chk("RST_wadr", a_wadr, 0);
        chk("RST_vd", a_d, 0);
        q_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (a_done) n_done++;
        end
        chk("RST_no_done", n_done, 0);
        chk("RST_ready_after", a_ready, 1);

        log_b.delete();
        issue(1, 8'h21, 16'd5, 16'd3, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 0);
        chk("P16_first_crom", b_crom_adr, 12'h210);
        wait_done(1, c, rh, bl);
        chk("P16_done_cycle", c, 289);
        chk("P16_ready_low", rh, 0);
        chk("P16_writes", log_b.size(), 256);
        @(negedge clk);
        chk("P16_sb_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/glyph_blit.md
GLYPH_BLIT -- requirements
Module: glyph_blit

Interface
REQ-001 SHALL have parameter PIXW, default 24, meaning pixel and colour width in bits.
REQ-002 SHALL have parameter VADR, default 16, meaning framebuffer write-address width.
REQ-003 SHALL have parameter CADR, default 11, meaning character-ROM address width.
REQ-004 SHALL have parameter FB_W, default 320, meaning framebuffer line pitch in pixels.
REQ-005 SHALL have parameter GLYPH_W, default 8, meaning glyph width in pixels and ROM data width in bits.
REQ-006 SHALL have parameter GLYPH_H, default 8, meaning glyph height in rows.
REQ-007 SHALL run on one clock with asynchronous, active-low reset.
REQ-008 SHALL have these ports:
- CLOCK_50  in  1  clock, all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- req_valid  in  1  blit request present.
- req_ready  out  1  block can accept a request.
- req_char  in  8  character code.
- req_x  in  VADR  top-left pixel column.
- req_y  in  VADR  top-left pixel row.
- req_fg  in  PIXW  colour for glyph bit 1.
- req_bg  in  PIXW  colour for glyph bit 0.
- req_transp  in  1  1 = do not write bit-0 pixels.
- crom_adr  out  CADR  character-ROM read address.
- crom_q  in  GLYPH_W  ROM row data, valid one cycle after crom_adr.
- vram_wadr  out  VADR  framebuffer write address.
- vram_d  out  PIXW  framebuffer write data.
- vram_we  out  1  framebuffer write enable.
- busy  out  1  blit in progress.
- done  out  1  one-cycle pulse when a blit completes.

Function
REQ-009 SHALL accept a request on a rising edge where req_valid and req_ready are both high, and SHALL latch all req_* fields at that edge.
REQ-010 SHALL drive req_ready high only in IDLE, so no request is accepted while busy.
REQ-011 SHALL implement the FSM IDLE -> FETCH -> WAIT -> DRAW, then FETCH for the next row or DONE after the last row, then DONE -> IDLE.
REQ-012 SHALL drive crom_adr = req_char*GLYPH_H + row in FETCH, truncated to CADR bits; row counts 0..GLYPH_H-1.
REQ-013 SHALL hold crom_adr through WAIT and SHALL capture crom_q into a row shift register at the WAIT -> DRAW transition.
REQ-014 SHALL spend exactly GLYPH_W cycles in DRAW, one pixel per cycle, taking the MSB of the row data as column 0.
REQ-015 SHALL drive vram_wadr = (y+row)*FB_W + x + col in each DRAW cycle, modulo 2^VADR, with no clipping.
REQ-016 SHALL drive vram_d = fg when the pixel bit is 1 and bg when it is 0.
REQ-017 SHALL assert vram_we in every DRAW cycle, except that when req_transp is set, vram_we is low for bit-0 pixels (the cycle is still consumed).
REQ-018 SHALL hold vram_we low in all states other than DRAW.
REQ-019 SHALL take exactly GLYPH_H*(GLYPH_W+2)+1 cycles from the accepting edge to the done pulse (81 cycles at defaults).
REQ-020 SHALL pulse done for exactly the one DONE cycle; busy SHALL be high in FETCH, WAIT, DRAW and DONE.
REQ-021 SHALL make the earliest next accept the cycle after DONE, i.e. back-to-back requests are separated by one IDLE cycle.
REQ-022 SHALL size intermediate address products wide enough to avoid overflow before the final modulo-2^VADR truncation.

Reset
REQ-023 SHALL, on RESET_N low, immediately return the FSM to IDLE with: req_ready=1, busy=0, done=0, vram_we=0, crom_adr=0, vram_wadr=0, vram_d=0.
REQ-024 SHALL, on reset during a blit, abort it with no further writes and no done pulse.
REQ-025 SHALL accept the first request no earlier than the first rising edge after RESET_N deasserts.

Structure
REQ-026 SHALL take the FSM state enum and the default GLYPH_W/GLYPH_H/FB_W constants from shared package vdp_pkg.
REQ-027 SHALL be a single module with no sub-module; the ROM and VRAM stay external and are wired at the vdp level.

Verification
REQ-028 SHALL test opaque 'T' (0x54) at x=100, y=0, fg=FFFFFF, bg=000000: first crom_adr=0x2A0, exactly 64 writes at addresses 100..107, 420..427, ..., 2340..2347, done on cycle 81.
REQ-029 SHALL test a transparent glyph whose row 0 is 0x81: row 0 produces writes only at col 0 and col 7, and the total write count equals the glyph popcount.
REQ-030 SHALL test req_valid held high for two requests: the second is accepted exactly two cycles after the first done edge (DONE, then one IDLE cycle), and req_ready stays low throughout the first blit.
REQ-031 SHALL test x=65535, y=0: the col 1 write address wraps to 0.
REQ-032 SHALL test RESET_N pulsed low at cycle 30 of a blit: vram_we falls asynchronously, no done pulse occurs, and req_ready=1 after reset.
REQ-033 SHALL test a parameter sweep at GLYPH_W=16, GLYPH_H=16, FB_W=640: latency of 289 cycles and 256 writes for an opaque glyph.
